// File: rtl/monte_carlo_pkg.sv
// Shared definitions for the monte-carlo move decider and its stat engine.
package monte_carlo_pkg;
  localparam int BOARD_W = 80;
  localparam int TILE_W  = 5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [1:0] STAT_CLEAR_CYCLES = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SCORE,
    S_DONE
  } mc_state_e;
endpackage

// File: rtl/monte_carlo_decider_ratio_compare.sv
// Compares average moves M/T against the current best without division.
module ratio_compare (
  input  logic [31:0] i_m,
  input  logic [31:0] i_t,
  input  logic [31:0] i_m_best,
  input  logic [31:0] i_t_best,
  input  logic        i_best_valid,
  output logic        o_better
);
  logic [63:0] w_lhs;
  logic [63:0] w_rhs;

  assign w_lhs    = 64'(i_m) * 64'(i_t_best);
  assign w_rhs    = 64'(i_m_best) * 64'(i_t);
  // strict compare keeps the lower direction on ties
  assign o_better = !i_best_valid || (w_lhs > w_rhs);
endmodule

// File: rtl/monte_carlo_decider.sv
// Runs monteCarloStat once per direction and reports the best average move count.
module monte_carlo_decider
  import monte_carlo_pkg::*;
#(
  parameter logic [31:0] TRIALS        = 32'd256,
  parameter logic [31:0] BUDGET        = 32'd100000,
  parameter logic [2:0]  RESTRICT_PROB = 3'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BOARD_W-1:0] board,
  input  logic [7:0]         seed,
  output logic               busy,
  output logic               done,
  output logic [1:0]         best_dir,
  output logic               best_valid,
  output logic [31:0]        best_moves,
  output logic [31:0]        best_trials,
  output logic               stat_rst,
  output logic [1:0]         stat_restrected,
  output logic [2:0]         stat_restrect_prob,
  output logic [BOARD_W-1:0] stat_board,
  output logic [7:0]         stat_seed,
  input  logic [31:0]        stat_total_move_count,
  input  logic [31:0]        stat_total_trial_count
);
  mc_state_e   r_state;
  logic [1:0]  r_clr_cnt;
  logic [31:0] r_cyc;
  logic        r_bvalid;
  logic [1:0]  r_bdir;
  logic [31:0] r_bmoves;
  logic [31:0] r_btrials;
  logic        w_better;
  logic        w_take;

  assign stat_restrect_prob = RESTRICT_PROB;
  assign stat_seed          = seed;

  ratio_compare u_cmp (
    .i_m          (stat_total_move_count),
    .i_t          (stat_total_trial_count),
    .i_m_best     (r_bmoves),
    .i_t_best     (r_btrials),
    .i_best_valid (r_bvalid),
    .o_better     (w_better)
  );

  // a direction with zero trials never competes
  assign w_take = (stat_total_trial_count != 32'd0) && w_better;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_clr_cnt       <= 2'd0;
      r_cyc           <= 32'd0;
      r_bvalid        <= 1'b0;
      r_bdir          <= DIR_UP;
      r_bmoves        <= 32'd0;
      r_btrials       <= 32'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      best_dir        <= DIR_UP;
      best_valid      <= 1'b0;
      best_moves      <= 32'd0;
      best_trials     <= 32'd0;
      stat_rst        <= 1'b1;
      stat_restrected <= DIR_UP;
      stat_board      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          stat_rst <= 1'b1;
          if (start) begin
            stat_board      <= board;
            stat_restrected <= DIR_UP;
            r_clr_cnt       <= 2'd0;
            r_bvalid        <= 1'b0;
            r_bdir          <= DIR_UP;
            r_bmoves        <= 32'd0;
            r_btrials       <= 32'd0;
            busy            <= 1'b1;
            r_state         <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cyc <= 32'd0;
          if (r_clr_cnt == STAT_CLEAR_CYCLES - 2'd1) begin
            stat_rst <= 1'b0;
            r_state  <= S_RUN;
          end else begin
            r_clr_cnt <= r_clr_cnt + 2'd1;
          end
        end
        S_RUN: begin
          r_cyc <= r_cyc + 32'd1;
          if ((stat_total_trial_count >= TRIALS) || (r_cyc == BUDGET - 32'd1))
            r_state <= S_SCORE;
        end
        S_SCORE: begin
          if (w_take) begin
            r_bvalid  <= 1'b1;
            r_bdir    <= stat_restrected;
            r_bmoves  <= stat_total_move_count;
            r_btrials <= stat_total_trial_count;
          end
          stat_rst <= 1'b1;
          if (stat_restrected == DIR_RIGHT) begin
            // publish including this final direction's result
            done        <= 1'b1;
            best_valid  <= w_take | r_bvalid;
            best_dir    <= w_take ? stat_restrected        : r_bdir;
            best_moves  <= w_take ? stat_total_move_count  : r_bmoves;
            best_trials <= w_take ? stat_total_trial_count : r_btrials;
            r_state     <= S_DONE;
          end else begin
            stat_restrected <= stat_restrected + 2'd1;
            r_clr_cnt       <= 2'd0;
            r_state         <= S_CLEAR;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_monte_carlo_decider.sv
// Randomized and directed checks of monte_carlo_decider against a stat-engine stub and average-based model.
module tb_monte_carlo_decider;
  localparam int TR  = 256;
  localparam int BUD = 50;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] board;
  logic [7:0]  seed;
  logic        busy, done, best_valid, stat_rst;
  logic [1:0]  best_dir, stat_restrected;
  logic [31:0] best_moves, best_trials;
  logic [2:0]  stat_restrect_prob;
  logic [79:0] stat_board;
  logic [7:0]  stat_seed;
  logic [31:0] stat_total_move_count, stat_total_trial_count;

  logic [31:0] sm [4];
  logic [31:0] st [4];
  logic [31:0] sd [4];
  logic [31:0] scyc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  monte_carlo_decider #(
    .TRIALS        (32'd256),
    .BUDGET        (32'(BUD)),
    .RESTRICT_PROB (3'd1)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .board                  (board),
    .seed                   (seed),
    .busy                   (busy),
    .done                   (done),
    .best_dir               (best_dir),
    .best_valid             (best_valid),
    .best_moves             (best_moves),
    .best_trials            (best_trials),
    .stat_rst               (stat_rst),
    .stat_restrected        (stat_restrected),
    .stat_restrect_prob     (stat_restrect_prob),
    .stat_board             (stat_board),
    .stat_seed              (stat_seed),
    .stat_total_move_count  (stat_total_move_count),
    .stat_total_trial_count (stat_total_trial_count)
  );

  // stat-engine stub: totals appear sd cycles after reset release and then hold
  always @(posedge clk) begin
    if (stat_rst) scyc <= 32'd0;
    else          scyc <= scyc + 32'd1;
  end

  always_comb begin
    stat_total_move_count  = 32'd0;
    stat_total_trial_count = 32'd0;
    if (!stat_rst && scyc >= sd[stat_restrected]) begin
      stat_total_move_count  = sm[stat_restrected];
      stat_total_trial_count = st[stat_restrected];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_dir(input int d, input int m, input int t, input int dl);
    sm[d] = 32'(m);
    st[d] = 32'(t);
    sd[d] = 32'(dl);
  endtask

  // RUN length a direction should take under this stub
  function automatic int exp_run(input int d);
    if (st[d] >= 32'(TR)) return (int'(sd[d]) + 1 < BUD) ? int'(sd[d]) + 1 : BUD;
    return BUD;
  endfunction

  // best direction by highest average move count, first one wins ties
  task automatic model(output logic v, output logic [1:0] bd, output logic [31:0] bm, output logic [31:0] bt);
    real best_avg, avg;
    v = 1'b0; bd = 2'd0; bm = 32'd0; bt = 32'd0; best_avg = 0.0;
    for (int d = 0; d < 4; d++) begin
      if (st[d] != 0) begin
        avg = real'(sm[d]) / real'(st[d]);
        if (!v || avg > best_avg) begin
          v = 1'b1; bd = 2'(d); bm = sm[d]; bt = st[d]; best_avg = avg;
        end
      end
    end
  endtask

  task automatic run_case(input string tag);
    logic        ev;
    logic [1:0]  ed;
    logic [31:0] em, et;
    logic [79:0] latched;
    int cycles, rstcnt, lat_exp, extra_done;
    int lowcnt [4];
    logic board_ok;
    model(ev, ed, em, et);
    lat_exp = 1;
    for (int d = 0; d < 4; d++) begin
      lat_exp += 3 + exp_run(d);
      lowcnt[d] = 0;
    end
    @(negedge clk);
    board = {$urandom, $urandom, 16'($urandom)};
    seed  = 8'($urandom);
    latched = board;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1; rstcnt = 0; board_ok = 1'b1;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_dir_start"}, stat_restrected, 0);
    while (!done && cycles < LIMIT) begin
      if (busy) begin
        if (stat_board !== latched) board_ok = 1'b0;
        if (stat_rst) rstcnt++;
        else lowcnt[stat_restrected]++;
      end
      if (cycles == 10) board = {$urandom, $urandom, 16'($urandom)};
      start = (cycles == 15);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_latency"}, cycles, lat_exp);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_stat_rst_cycles"}, rstcnt, 8);
    chk({tag, "_board_stable"}, board_ok, 1);
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_run_dir%0d", tag, d), lowcnt[d], exp_run(d) + 1);
    chk({tag, "_best_valid"}, best_valid, ev);
    chk({tag, "_best_dir"}, best_dir, ed);
    chk({tag, "_best_moves"}, best_moves, em);
    chk({tag, "_best_trials"}, best_trials, et);
    extra_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk({tag, "_extra_done"}, extra_done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_stat_rst_idle"}, stat_rst, 1);
    chk({tag, "_hold_dir"}, best_dir, ed);
    chk({tag, "_hold_moves"}, best_moves, em);
  endtask

  initial begin
    int cycles;
    rst = 1'b0; start = 1'b0; board = '0; seed = 8'h5a;
    for (int d = 0; d < 4; d++) set_dir(d, 0, 0, 0);
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_best_valid", best_valid, 0);
    chk("rst_best_dir", best_dir, 0);
    chk("rst_best_moves", best_moves, 0);
    chk("rst_best_trials", best_trials, 0);
    chk("rst_stat_rst", stat_rst, 1);
    chk("rst_stat_dir", stat_restrected, 0);
    chk("rst_stat_board", stat_board, 0);
    chk("rst_prob", stat_restrect_prob, 1);
    chk("seed_fwd", stat_seed, 8'h5a);
    @(negedge clk);
    rst = 1'b1;

    set_dir(0, 1000, 256, 3); set_dir(1, 3000, 256, 7);
    set_dir(2, 2000, 256, 0); set_dir(3, 500, 256, 12);
    run_case("basic");

    set_dir(0, 4000, 256, 5); set_dir(1, 1000, 256, 2);
    set_dir(2, 4000, 256, 1); set_dir(3, 3999, 256, 4);
    run_case("tie");

    set_dir(0, 600, 100, 4); set_dir(1, 0, 0, 0);
    set_dir(2, 0, 0, 0);     set_dir(3, 1300, 200, 9);
    run_case("unequal");

    for (int d = 0; d < 4; d++) set_dir(d, 0, 0, 0);
    run_case("invalid");

    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 4; d++) begin
        case ($urandom_range(0, 3))
          0:       set_dir(d, 0, 0, 0);
          1:       set_dir(d, int'($urandom_range(0, 5000)), int'($urandom_range(1, 255)), int'($urandom_range(0, 20)));
          default: set_dir(d, int'($urandom_range(0, 20000)), int'($urandom_range(256, 300)), int'($urandom_range(0, 20)));
        endcase
      end
      run_case($sformatf("rand%0d", i));
    end

    // abort during RUN of direction 2
    for (int d = 0; d < 4; d++) set_dir(d, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!(busy && !stat_rst && stat_restrected == 2'd2) && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    chk("abort_reached_dir2", stat_restrected, 2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_stat_rst", stat_rst, 1);
    chk("abort_stat_dir", stat_restrected, 0);
    chk("abort_stat_board", stat_board, 0);
    chk("abort_best_valid", best_valid, 0);
    chk("abort_best_moves", best_moves, 0);
    @(negedge clk);
    rst = 1'b1;

    set_dir(0, 900, 256, 2); set_dir(1, 100, 50, 1);
    set_dir(2, 2600, 256, 6); set_dir(3, 0, 0, 0);
    run_case("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/monte_carlo_decider.md
# monte_carlo_decider

Move-selection controller that consumes the `monteCarloStat` statistics interface. For a latched 80-bit board it evaluates the four directions in turn. Each direction gets its own window on a single external `monteCarloStat` instance, with the first move restricted to that direction. The controller then compares average move counts and reports the best direction to the game-control logic.

## Interface
Parameters:
- `TRIALS`, 32'd256: trial count that closes a direction's window.
- `BUDGET`, 32'd100000: maximum RUN cycles per direction; the window also closes on timeout.
- `RESTRICT_PROB`, 3'd1: constant driven on `stat_restrect_prob`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request evaluation; sampled only in IDLE.
- `board` in 80: 16 tiles × 5-bit log2 exponent; latched on accepted `start`.
- `seed` in 8: forwarded unchanged to `stat_seed`.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse when the result is valid.
- `best_dir` out 2: winning direction, in the same encoding as `restrected`.
- `best_valid` out 1: at least one direction produced more than zero trials.
- `best_moves` out 32 / `best_trials` out 32: the winner's totals.
- `stat_rst` out 1: active-high reset into `monteCarloStat`.
- `stat_restrected` out 2: current direction under evaluation.
- `stat_restrect_prob` out 3: driven to `RESTRICT_PROB`.
- `stat_board` out 80: latched board.
- `stat_seed` out 8: forwarded `seed`.
- `stat_total_move_count` in 32 / `stat_total_trial_count` in 32: live accumulators from `monteCarloStat`.

## Operation
States and transitions:
- **IDLE**
  - `start=1` → latch `board`, set `dir=0`, go to CLEAR.
  - `start=0` → stay.
- **CLEAR**
  - Hold `stat_rst=1` for exactly 2 cycles, then go to RUN.
  - Clear the cycle counter.
- **RUN**
  - Increment the cycle counter each cycle.
  - Exit to SCORE when either:
    - `stat_total_trial_count >= TRIALS`, or
    - cycle counter reaches `BUDGET - 1`.
  - Both conditions in the same cycle → SCORE. There is no distinction between the two exits.
- **SCORE** (1 cycle)
  - Sample moves M and trials T.
  - If T==0: the direction is invalid and is never selected.
  - Otherwise: replace the current best when there is no valid best yet, or when M·T_best > M_best·T. Use 64-bit unsigned products and strict greater-than, so ties keep the lower direction index.
  - If `dir==3` → DONE. Otherwise increment `dir` and go to CLEAR.
- **DONE** (1 cycle)
  - Pulse `done`; update the `best_*` outputs.
  - Return to IDLE.

Rules:
- `start` outside IDLE is ignored; there is no queueing.
- `best_*` outputs hold their values until the next DONE.
- If all four directions are invalid: `best_valid=0`, `best_dir=0`, `best_moves=0`, `best_trials=0`.
- `stat_board` and `stat_restrected` are stable throughout CLEAR, RUN and SCORE of a direction.
- Counter width is 32 bits; `BUDGET` ≥ 2 is required.

## Timing
- Reset values (asynchronous, while `rst=0`):
  - State IDLE; `busy=0`, `done=0`.
  - `best_dir=0`, `best_valid=0`, `best_moves=0`, `best_trials=0`.
  - `stat_rst=1`, so the stat engine is held in reset; `stat_restrected=0`; `stat_board=0`.
  - `stat_restrect_prob=RESTRICT_PROB`.
- Reset mid-operation aborts immediately; the next `start` re-evaluates from `dir=0`.
- In IDLE, `stat_rst=1` so the engine does not run.
- Per-direction latency: 2 (CLEAR) + R (RUN, 1 ≤ R ≤ `BUDGET`) + 1 (SCORE).
- Total `start`→`done`: 1 + Σ(3+Rᵢ) cycles; `done` asserts in the cycle after the final SCORE.
- Stat inputs are sampled registered in SCORE, i.e. the value present one cycle after the RUN exit condition. This tolerates one extra trial completing.

## Structure
- Shared package `monte_carlo_pkg`:
  - `BOARD_W=80`, `TILE_W=5`.
  - Direction encodings `DIR_*` (2-bit, shared with `monteCarloStat`).
  - State enum for this FSM.
  - `STAT_CLEAR_CYCLES=2`.
- One sub-module, `ratio_compare`: combinational 32×32 cross-multiply comparator with inputs (M, T, M_best, T_best, best_valid) and output `better`. Isolating it allows later pipelining if timing fails.

## Test plan
Use a behavioural stub of `monteCarloStat` driven per `stat_restrected`.
- Stub gives per-direction (M,T) = (0:1000/256, 1:3000/256, 2:2000/256, 3:500/256) → `done` with `best_dir=1`, `best_moves=3000`, `best_trials=256`, `best_valid=1`.
- Tie: directions 0 and 2 both 4000/256, others lower → `best_dir=0`.
- Unequal trials: dir0 600/100 (avg 6.0), dir3 1300/200 (avg 6.5), others 0/0 with `BUDGET=50` → `best_dir=3`. The timed-out directions take exactly 50 RUN cycles each.
- All directions return T=0 with `BUDGET=10` → `done` after 1+4·13=53 cycles with `best_valid=0`, `best_dir=0`.
- `rst` low during RUN of dir2 → outputs return to reset values at once, `stat_rst=1`. A fresh `start` restarts with `stat_restrected=0`; `start` pulses while `busy=1` cause no extra `done`.
- `stat_rst` is high exactly 2 cycles per direction; `stat_board` equals the board latched at `start` even if `board` changes mid-run.
